exec_wb_stage: RTL

//  Multicycle execute/write-back stage that drives the 16x8 register file.

---
 rtl/exec_wb_stage_pkg.sv | 21 ++
 rtl/exec_wb_stage_alu8.sv | 37 +++
 rtl/exec_wb_stage.sv | 106 ++++++++++
 3 files changed

// File: rtl/exec_wb_stage_pkg.sv
// Shared definitions for the execute/write-back stage: opcode encodings and
// the four-state sequencing used by the top-level FSM.
package exec_wb_stage_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_MOV = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

endpackage

// File: rtl/exec_wb_stage_alu8.sv
// Combinational ALU for the execute stage; carry doubles as the borrow flag
// for SUB/CMP and is cleared for all logical ops.
module alu8
    import exec_wb_stage_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic             c
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // One extra bit on each arithmetic path captures carry-out / borrow.
    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} - {1'b0, b};
        res  = '0;
        c    = 1'b0;
        case (op)
            OP_ADD: {c, res} = sum;
            OP_SUB: {c, res} = diff;
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_NOT: res = ~a;
            OP_MOV: res = b;
            OP_CMP: {c, res} = diff;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/exec_wb_stage.sv
// Multicycle execute/write-back stage: accepts one ALU instruction, reads its
// operands from the register file, computes, and writes the result back.
module exec_wb_stage
    import exec_wb_stage_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [AW-1:0]    in_rd,
    input  logic [AW-1:0]    in_rs1,
    input  logic [AW-1:0]    in_rs2,
    input  logic [WIDTH-1:0] in_imm,
    input  logic             in_use_imm,
    output logic [AW-1:0]    ra1,
    output logic [AW-1:0]    ra2,
    input  logic [WIDTH-1:0] rd1,
    input  logic [WIDTH-1:0] rd2,
    output logic [AW-1:0]    wa3,
    output logic [WIDTH-1:0] wd3,
    output logic             we,
    output logic             flag_z,
    output logic             flag_c,
    output logic             done
);

    state_t           state;
    logic [2:0]       op_lat;
    logic [AW-1:0]    rd_lat;
    logic [WIDTH-1:0] imm_lat;
    logic             use_imm_lat;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;

    alu8 #(.WIDTH(WIDTH)) u_alu (
        .op  (op_lat),
        .a   (opa),
        .b   (opb),
        .res (alu_res),
        .c   (alu_c)
    );

    // Instruction fields are captured only on the accept edge, so upstream
    // may change in_* freely while an instruction is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            op_lat      <= '0;
            rd_lat      <= '0;
            imm_lat     <= '0;
            use_imm_lat <= 1'b0;
            ra1         <= '0;
            ra2         <= '0;
            opa         <= '0;
            opb         <= '0;
            res         <= '0;
            flag_z      <= 1'b0;
            flag_c      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_lat      <= in_op;
                        rd_lat      <= in_rd;
                        imm_lat     <= in_imm;
                        use_imm_lat <= in_use_imm;
                        ra1         <= in_rs1;
                        ra2         <= in_rs2;
                        state       <= S_READ;
                    end
                end
                S_READ: begin
                    opa   <= rd1;
                    opb   <= use_imm_lat ? imm_lat : rd2;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    res    <= alu_res;
                    flag_z <= (alu_res == '0);
                    flag_c <= alu_c;
                    state  <= S_WB;
                end
                S_WB: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Write-port controls decode straight from state so an async reset
    // drops we/done in the same instant.
    assign in_ready = (state == S_IDLE);
    assign done     = (state == S_WB);
    assign we       = (state == S_WB) && (op_lat != OP_CMP);
    assign wa3      = rd_lat;
    assign wd3      = res;

endmodule
